release_rr_lock_arbiter: RTL and testbench
==========================================

Name: release_rr_lock_arbiter

Overview:
- N-input round-robin arbiter for the outer-memory release/writeback channel; merges per-client release streams onto one outbound port.
- Multi-beat releases that carry data are locked to one requester until all beats have transferred.
- Arbitration priority rotates after every completed message.
- Sits between the per-tile client release queues and the outer coherence manager's release input.

Parameters:
N_IN, 4, number of requesters (2..8)
BEATS, 4, data beats per data-carrying release (power of 2, >=2)
DATA_W, 128, width of bits_data
ADDR_W, 26, width of bits_addr_block
XID_W, 6, width of bits_client_xact_id
SEL_W, 2, clog2(N_IN); width of io_chosen

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous active-low reset; sampled on the clk rising edge; 0 = in reset
io_in_valid  in  N_IN  per-requester valid
io_in_ready  out  N_IN  per-requester ready
io_in_bits_addr_beat  in  2*N_IN  flattened; requester i at [2i+1:2i]
io_in_bits_addr_block  in  ADDR_W*N_IN  flattened, same packing
io_in_bits_client_xact_id  in  XID_W*N_IN  flattened
io_in_bits_voluntary  in  N_IN  per requester
io_in_bits_r_type  in  3*N_IN  flattened
io_in_bits_data  in  DATA_W*N_IN  flattened
io_out_ready  in  1  downstream ready
io_out_valid  out  1  valid of selected requester
io_out_bits_addr_beat, io_out_bits_addr_block, io_out_bits_client_xact_id, io_out_bits_voluntary, io_out_bits_r_type, io_out_bits_data  out  field widths  fields of selected requester
io_chosen  out  SEL_W  index of selected requester
io_locked  out  1  arbiter is mid-message

Behaviour:
- State registers:
  - locked (1 bit), reset 0
  - lock_idx (SEL_W), reset 0
  - beat_cnt (clog2(BEATS)), reset 0
  - rr_ptr (SEL_W), reset 0
- Reset: while reset==0, all four registers load their reset values, overriding any concurrent fire.
- Datapath is combinational, zero latency, with no input or output registering.
- hasData = (r_type==0) | (r_type==1) | (r_type==2), evaluated on the io_out fields.
- fire = io_out_valid & io_out_ready.
- Selection:
  - If locked: sel = lock_idx.
  - Else: sel = first i with io_in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_IN.
  - Else, if no input is valid: sel = rr_ptr.
- Outputs:
  - io_chosen = sel.
  - io_out_valid and all io_out_bits fields are those of requester sel.
  - io_in_ready[i] = io_out_ready & (i==sel); exactly one ready is possible per cycle, and only while unlocked or to lock_idx.
  - io_locked = locked.
  - While reset is asserted, the outputs still follow the inputs combinationally using the reset register values: sel search starts at 0.
- Beat counting: on fire with hasData, beat_cnt <= beat_cnt+1, wrapping modulo BEATS. The counter ignores io_out_bits_addr_beat.
- State machine, IDLE (locked=0) and BURST (locked=1):
  - IDLE, fire & hasData: go to BURST; lock_idx <= sel; beat_cnt <= 1; rr_ptr unchanged.
  - IDLE, fire & !hasData: single-beat message complete; stay IDLE; rr_ptr <= sel+1 mod N_IN.
  - BURST, fire & beat_cnt!=BEATS-1: stay BURST; beat_cnt++.
  - BURST, fire & beat_cnt==BEATS-1: go to IDLE; beat_cnt <= 0; rr_ptr <= lock_idx+1 mod N_IN.
  - BURST with the locked input deasserting valid: stay BURST, io_out_valid=0, and all other requesters are stalled.
- Boundary conditions:
  - rr_ptr wraps from N_IN-1 to 0.
  - For non-power-of-2 N_IN, index arithmetic is mod N_IN, not mod 2^SEL_W.
  - io_out_ready=0 gives no state change.
  - A reset asserted mid-BURST abandons the burst with no drain; the next cycle is IDLE with priority at input 0.
- The block never issues a transfer from a requester whose valid is 0. A requester's valid or bits changing while it is not selected is ignored.

Test Plan:
- After reset, all valids=0xF, r_type=3 (no data), out_ready=1 for 4 cycles -> io_chosen sequence 0,1,2,3; io_locked stays 0; rr_ptr ends at 0.
- io_in_valid=0b0011, in0 r_type=0 (data), out_ready=1 -> chosen=0 for 4 consecutive fires, io_in_ready[1]=0 throughout, io_locked=1 on cycles 2-4; fifth cycle chosen=1.
- Locked on in2 after beat 1; in2 valid drops for 3 cycles while in0, in1, in3 are valid -> io_out_valid=0, all io_in_ready=0, beat_cnt holds at 1; burst resumes and completes after 3 more fires.
- Burst in progress with out_ready toggling 1,0,1,0,... -> exactly 4 fires before unlock, and the data on each fire matches in0's presented beat.
- reset=0 asserted after beat 2 of a burst on in3 -> next cycle io_locked=0; with all valid, chosen=0.
- Only in3 valid with rr_ptr=1 -> chosen=3, fire occurs; then rr_ptr=0, so with all valid the next chosen=0.

Source files
------------

// File: rtl/release_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// release_rr_lock_arbiter
//
// Round-robin arbiter for the outer-memory release/writeback channel. It
// merges the per-tile client release streams onto the single release input
// of the outer coherence manager. A data-carrying release (BEATS beats) locks
// the arbiter to its requester until every beat has transferred. Priority
// rotates to the requester after the winner once a message completes.
//
// The datapath is purely combinational (zero latency); only the arbitration
// state is registered.
//
// Ports:
//   clk                        clock, all state updates on the rising edge
//   reset                      synchronous active-low reset (0 = in reset)
//   io_in_valid  [N_IN]        per-requester valid
//   io_in_ready  [N_IN]        per-requester ready (at most one set)
//   io_in_bits_*               flattened per-requester fields, requester i
//                              occupies slice [W*(i+1)-1 : W*i]
//   io_out_ready               downstream ready
//   io_out_valid               valid of the selected requester
//   io_out_bits_*              fields of the selected requester
//   io_chosen    [SEL_W]       index of the selected requester
//   io_locked                  arbiter is in the middle of a multi-beat message
//
// State table:
//   state   | meaning
//   S_IDLE  | no message in flight; winner picked by round-robin from rr_ptr
//   S_BURST | multi-beat data release in flight; output pinned to lock_idx
// ---------------------------------------------------------------------------
module release_rr_lock_arbiter #(
  parameter int N_IN   = 4,
  parameter int BEATS  = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 26,
  parameter int XID_W  = 6,
  parameter int SEL_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       io_in_valid,
  output logic [N_IN-1:0]       io_in_ready,
  input  logic [2*N_IN-1:0]     io_in_bits_addr_beat,
  input  logic [ADDR_W*N_IN-1:0] io_in_bits_addr_block,
  input  logic [XID_W*N_IN-1:0] io_in_bits_client_xact_id,
  input  logic [N_IN-1:0]       io_in_bits_voluntary,
  input  logic [3*N_IN-1:0]     io_in_bits_r_type,
  input  logic [DATA_W*N_IN-1:0] io_in_bits_data,
  input  logic                  io_out_ready,
  output logic                  io_out_valid,
  output logic [1:0]            io_out_bits_addr_beat,
  output logic [ADDR_W-1:0]     io_out_bits_addr_block,
  output logic [XID_W-1:0]      io_out_bits_client_xact_id,
  output logic                  io_out_bits_voluntary,
  output logic [2:0]            io_out_bits_r_type,
  output logic [DATA_W-1:0]     io_out_bits_data,
  output logic [SEL_W-1:0]      io_chosen,
  output logic                  io_locked
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  // Register view used by the combinational path. While reset is held the
  // outputs behave as if the registers already held their reset values, so
  // a reset mid-burst immediately unpins the output and restarts the search
  // at requester 0.
  state_t            state_v;
  logic [SEL_W-1:0]  lock_idx_v;
  logic [SEL_W-1:0]  rr_ptr_v;

  assign state_v    = reset ? state_q    : S_IDLE;
  assign lock_idx_v = reset ? lock_idx_q : '0;
  assign rr_ptr_v   = reset ? rr_ptr_q   : '0;

  // Index arithmetic is modulo N_IN, which matters when N_IN is not a
  // power of two.
  function automatic logic [SEL_W-1:0] add_mod(input logic [SEL_W-1:0] base,
                                               input int              off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_IN) sum = sum - N_IN;
    return SEL_W'(sum);
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] x);
    if (x == SEL_W'(N_IN - 1)) return '0;
    return x + SEL_W'(1);
  endfunction

  // Unpack the flattened request fields into per-requester arrays.
  logic [1:0]        beat_a  [N_IN];
  logic [ADDR_W-1:0] block_a [N_IN];
  logic [XID_W-1:0]  xid_a   [N_IN];
  logic [2:0]        rtype_a [N_IN];
  logic [DATA_W-1:0] data_a  [N_IN];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign beat_a[gi]  = io_in_bits_addr_beat[2*gi +: 2];
    assign block_a[gi] = io_in_bits_addr_block[ADDR_W*gi +: ADDR_W];
    assign xid_a[gi]   = io_in_bits_client_xact_id[XID_W*gi +: XID_W];
    assign rtype_a[gi] = io_in_bits_r_type[3*gi +: 3];
    assign data_a[gi]  = io_in_bits_data[DATA_W*gi +: DATA_W];
  end

  // Requester selection: pinned while locked, otherwise the first valid
  // requester at or after rr_ptr; rr_ptr itself when nobody is valid.
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    sel   = rr_ptr_v;
    cand  = '0;
    found = 1'b0;
    if (state_v == S_BURST) begin
      sel = lock_idx_v;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        cand = add_mod(rr_ptr_v, k);
        if (!found && io_in_valid[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Output mux.
  assign io_chosen                  = sel;
  assign io_out_valid               = io_in_valid[sel];
  assign io_out_bits_addr_beat      = beat_a[sel];
  assign io_out_bits_addr_block     = block_a[sel];
  assign io_out_bits_client_xact_id = xid_a[sel];
  assign io_out_bits_voluntary      = io_in_bits_voluntary[sel];
  assign io_out_bits_r_type         = rtype_a[sel];
  assign io_out_bits_data           = data_a[sel];
  assign io_locked                  = (state_v == S_BURST);

  // Ready goes only to the selected requester, so a stalled lock owner
  // blocks everyone else.
  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      io_in_ready[i] = io_out_ready && (sel == SEL_W'(i));
    end
  end

  logic has_data;
  logic fire;

  assign has_data = (io_out_bits_r_type == 3'd0) ||
                    (io_out_bits_r_type == 3'd1) ||
                    (io_out_bits_r_type == 3'd2);
  assign fire     = io_out_valid && io_out_ready;

  // Next-state logic. The beat counter advances on its own and never
  // consults addr_beat from the requester.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (has_data) begin
            state_d    = S_BURST;
            lock_idx_d = sel;
            beat_cnt_d = CNT_W'(1);
          end else begin
            rr_ptr_d = wrap_inc(sel);
          end
        end
      end
      S_BURST: begin
        if (fire) begin
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = wrap_inc(lock_idx_q);
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_release_rr_lock_arbiter.sv
module tb_release_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int BT = 4;
  localparam int DW = 128;
  localparam int AW = 26;
  localparam int XW = 6;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset;
  logic out_ready;

  logic [N-1:0]  v;
  logic [N-1:0]  vol;
  logic [1:0]    beat_a [N];
  logic [AW-1:0] blk_a  [N];
  logic [XW-1:0] xid_a  [N];
  logic [2:0]    rt_a   [N];
  logic [DW-1:0] dat_a  [N];

  logic [2*N-1:0]  beat_f;
  logic [AW*N-1:0] blk_f;
  logic [XW*N-1:0] xid_f;
  logic [3*N-1:0]  rt_f;
  logic [DW*N-1:0] dat_f;

  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [1:0]    o_beat;
  logic [AW-1:0] o_blk;
  logic [XW-1:0] o_xid;
  logic          o_vol;
  logic [2:0]    o_rt;
  logic [DW-1:0] o_dat;
  logic [SW-1:0] chosen;
  logic          locked;

  always_comb begin
    beat_f = '0;
    blk_f  = '0;
    xid_f  = '0;
    rt_f   = '0;
    dat_f  = '0;
    for (int i = 0; i < N; i++) begin
      beat_f[2*i +: 2]   = beat_a[i];
      blk_f[AW*i +: AW]  = blk_a[i];
      xid_f[XW*i +: XW]  = xid_a[i];
      rt_f[3*i +: 3]     = rt_a[i];
      dat_f[DW*i +: DW]  = dat_a[i];
    end
  end

  release_rr_lock_arbiter #(
    .N_IN(N), .BEATS(BT), .DATA_W(DW), .ADDR_W(AW), .XID_W(XW), .SEL_W(SW)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .io_in_valid                (v),
    .io_in_ready                (in_ready),
    .io_in_bits_addr_beat       (beat_f),
    .io_in_bits_addr_block      (blk_f),
    .io_in_bits_client_xact_id  (xid_f),
    .io_in_bits_voluntary       (vol),
    .io_in_bits_r_type          (rt_f),
    .io_in_bits_data            (dat_f),
    .io_out_ready               (out_ready),
    .io_out_valid               (out_valid),
    .io_out_bits_addr_beat      (o_beat),
    .io_out_bits_addr_block     (o_blk),
    .io_out_bits_client_xact_id (o_xid),
    .io_out_bits_voluntary      (o_vol),
    .io_out_bits_r_type         (o_rt),
    .io_out_bits_data           (o_dat),
    .io_chosen                  (chosen),
    .io_locked                  (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: message-level view of the arbiter.
  int m_locked = 0;  // a data message is in flight
  int m_owner  = 0;  // requester owning that message
  int m_done   = 0;  // beats of it already transferred
  int m_rr     = 0;  // requester with highest priority

  int obs_chosen;
  int obs_locked;
  int obs_valid;
  int obs_fire;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sel();
    int rr;
    rr = reset ? m_rr : 0;
    if (reset && m_locked != 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return rr;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      beat_a[i] = 2'($urandom());
      blk_a[i]  = AW'($urandom());
      xid_a[i]  = XW'($urandom());
      vol[i]    = 1'($urandom());
      dat_a[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int s;
    logic [N-1:0] er;
    #3;
    s  = exp_sel();
    er = '0;
    if (out_ready) er[s] = 1'b1;
    chk("chosen",     128'(chosen),    128'(s));
    chk("out_valid",  128'(out_valid), 128'(v[s]));
    chk("in_ready",   128'(in_ready),  128'(er));
    chk("locked",     128'(locked),    128'(reset && m_locked != 0));
    chk("data",       128'(o_dat),     128'(dat_a[s]));
    chk("addr_block", 128'(o_blk),     128'(blk_a[s]));
    chk("xact_id",    128'(o_xid),     128'(xid_a[s]));
    chk("addr_beat",  128'(o_beat),    128'(beat_a[s]));
    chk("voluntary",  128'(o_vol),     128'(vol[s]));
    chk("r_type",     128'(o_rt),      128'(rt_a[s]));
    obs_chosen = int'(chosen);
    obs_locked = int'(locked);
    obs_valid  = int'(out_valid);
    obs_fire   = int'(out_valid && out_ready);
    @(posedge clk);
    if (!reset) begin
      m_locked = 0; m_owner = 0; m_done = 0; m_rr = 0;
    end else if (v[s] && out_ready) begin
      if (m_locked == 0) begin
        if (rt_a[s] <= 3'd2) begin
          m_locked = 1; m_owner = s; m_done = 1;
        end else begin
          m_rr = (s + 1) % N;
        end
      end else if (m_done == BT - 1) begin
        m_locked = 0; m_done = 0; m_rr = (m_owner + 1) % N;
      end else begin
        m_done++;
      end
    end
    #1;
  endtask

  task automatic set_rt_all(input logic [2:0] r);
    for (int i = 0; i < N; i++) rt_a[i] = r;
  endtask

  initial begin
    int nf;
    reset = 1'b0; out_ready = 1'b0; v = '0;
    set_rt_all(3'd3);
    rand_fields();

    // Reset state
    repeat (2) cycle();
    chk("rst_locked", 128'(obs_locked), 128'(0));
    chk("rst_chosen", 128'(obs_chosen), 128'(0));
    reset = 1'b1;

    // Single-beat messages rotate priority 0,1,2,3
    v = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_fields(); cycle();
      chk("tp1_seq", 128'(obs_chosen), 128'(k));
      chk("tp1_unlocked", 128'(obs_locked), 128'(0));
    end

    // Data burst on in0 holds off in1
    v = 4'b0011; rt_a[0] = 3'd0; rt_a[1] = 3'd3;
    for (int k = 0; k < 4; k++) begin
      rand_fields(); cycle();
      chk("tp2_chosen", 128'(obs_chosen), 128'(0));
      chk("tp2_locked", 128'(obs_locked), 128'(k > 0));
    end
    rand_fields(); cycle();
    chk("tp2_next", 128'(obs_chosen), 128'(1));

    // Lock on in2, owner drops valid for three cycles
    v = 4'hF; set_rt_all(3'd3); rt_a[2] = 3'd1;
    rand_fields(); cycle();
    chk("tp3_first", 128'(obs_chosen), 128'(2));
    v[2] = 1'b0;
    repeat (3) begin
      rand_fields(); cycle();
      chk("tp3_stall", 128'(obs_valid), 128'(0));
      chk("tp3_held",  128'(obs_chosen), 128'(2));
    end
    v[2] = 1'b1;
    repeat (3) begin
      rand_fields(); cycle();
      chk("tp3_resume", 128'(obs_chosen), 128'(2));
    end
    rt_a[2] = 3'd3;
    rand_fields(); cycle();
    chk("tp3_unlock", 128'(obs_locked), 128'(0));
    chk("tp3_rotate", 128'(obs_chosen), 128'(3));

    // Burst on in0 with out_ready toggling
    v = 4'b0001; rt_a[0] = 3'd2; nf = 0;
    for (int c = 0; c < 8; c++) begin
      out_ready = ((c % 2) == 0);
      rand_fields(); cycle();
      nf += obs_fire;
    end
    chk("tp4_fires", 128'(nf), 128'(4));
    out_ready = 1'b1; rt_a[0] = 3'd3;
    rand_fields(); cycle();
    chk("tp4_unlock", 128'(obs_locked), 128'(0));

    // Reset mid-burst on in3
    v = 4'b1000; rt_a[3] = 3'd0;
    repeat (2) begin rand_fields(); cycle(); end
    chk("tp5_owner", 128'(obs_chosen), 128'(3));
    reset = 1'b0; v = 4'hF; set_rt_all(3'd3);
    rand_fields(); cycle();
    reset = 1'b1;
    rand_fields(); cycle();
    chk("tp5_unlock", 128'(obs_locked), 128'(0));
    chk("tp5_chosen", 128'(obs_chosen), 128'(0));

    // Only in3 valid with rr_ptr=1, then wrap back to 0
    v = 4'b1000;
    rand_fields(); cycle();
    chk("tp6_only3", 128'(obs_chosen), 128'(3));
    chk("tp6_fire",  128'(obs_fire),   128'(1));
    v = 4'hF;
    rand_fields(); cycle();
    chk("tp6_wrap", 128'(obs_chosen), 128'(0));

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) != 0);
      v         = N'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      rand_fields();
      for (int i = 0; i < N; i++) rt_a[i] = 3'($urandom_range(0, 7));
      if (m_locked != 0) rt_a[m_owner] = 3'($urandom_range(0, 2));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
